// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Serial PRBS checker. Self-seeds a shadow Fibonacci LFSR from the
//            received stream, qualifies lock, then counts bit errors.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] TAPS        = 3'b101,
    parameter int               LOCK_CNT    = 4,
    parameter int               LOSS_THRESH = 3,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W   = $clog2(WIDTH + 1);
    localparam int MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

    localparam logic [1:0] c_SEED   = 2'd0;
    localparam logic [1:0] c_QUAL   = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [FILL_W-1:0]   c_FILL_LAST   = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0]   c_FILL_ONE    = FILL_W'(1);
    localparam logic [MATCH_W-1:0]  c_MATCH_LAST  = MATCH_W'(LOCK_CNT - 1);
    localparam logic [CONSEC_W-1:0] c_CONSEC_LAST = CONSEC_W'(LOSS_THRESH - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX     = '1;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_shadow;
    logic [FILL_W-1:0]   r_fill;
    logic [MATCH_W-1:0]  r_match;
    logic [CONSEC_W-1:0] r_consec;
    logic                r_locked;
    logic                r_err_pulse;
    logic [CNT_W-1:0]    r_err_count;
    logic [CNT_W-1:0]    r_bit_count;

    logic             w_exp;
    logic [WIDTH-1:0] w_shift;
    logic             w_check;
    logic             w_miss;

    assign w_exp   = ^(r_shadow & TAPS);
    assign w_shift = {r_shadow[WIDTH-2:0], in_bit};
    assign w_check = in_valid && (r_state == c_LOCKED);
    assign w_miss  = w_check && (in_bit != w_exp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_SEED;
            r_shadow    <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_consec    <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    c_SEED: begin
                        r_shadow <= w_shift;
                        if (r_fill == c_FILL_LAST) begin
                            // An all-zero seed would lock the LFSR up, so refill instead.
                            r_fill <= '0;
                            if (w_shift != '0) begin
                                r_state <= c_QUAL;
                                r_match <= '0;
                            end
                        end else begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                    c_QUAL: begin
                        r_shadow <= w_shift;
                        if (in_bit == w_exp) begin
                            if (r_match == c_MATCH_LAST) begin
                                r_state  <= c_LOCKED;
                                r_locked <= 1'b1;
                                r_match  <= '0;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else begin
                            // The offending bit is already in the shadow as seed bit one.
                            r_state <= c_SEED;
                            r_fill  <= c_FILL_ONE;
                            r_match <= '0;
                        end
                    end
                    c_LOCKED: begin
                        r_shadow <= {r_shadow[WIDTH-2:0], w_exp};
                        if (w_miss) begin
                            r_err_pulse <= 1'b1;
                            if (r_consec == c_CONSEC_LAST) begin
                                r_state  <= c_SEED;
                                r_locked <= 1'b0;
                                r_fill   <= '0;
                                r_consec <= '0;
                            end else begin
                                r_consec <= r_consec + 1'b1;
                            end
                        end else begin
                            r_consec <= '0;
                        end
                    end
                    default: begin
                        r_state  <= c_SEED;
                        r_locked <= 1'b0;
                        r_fill   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
            r_bit_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            if (w_check && (r_bit_count != c_CNT_MAX)) begin
                r_bit_count <= r_bit_count + 1'b1;
            end
            if (w_miss && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random sequence checker that sits directly downstream of the team's Fibonacci LFSR generator. It consumes one generated bit per valid cycle, which is the generator's LSB (the newly inserted feedback bit). It self-seeds a shadow LFSR from the incoming stream, qualifies lock over a programmable number of matching bits, then free-runs the shadow LFSR to count bit errors one-for-one. It declares loss of lock after a run of consecutive errors.

## Interface
Parameters:
- WIDTH, 3: LFSR length; must equal the generator's WIDTH; minimum 2.
- TAPS, 3'b101: feedback mask; must equal the generator's TAPS.
- LOCK_CNT, 4: consecutive matching bits required after seeding to declare lock; minimum 1.
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force loss of lock; minimum 1.
- CNT_W, 16: width of the error and bit counters.

Ports:
- clk, input, 1: clock; all state is updated on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_bit is meaningful this cycle.
- in_bit, input, 1: received sequence bit, taken from generator lfsr_out[0].
- clear, input, 1: synchronous clear of err_count and bit_count.
- locked, output, 1: checker is in LOCKED.
- err_pulse, output, 1: one-cycle flag marking a mismatch detected in LOCKED.
- err_count, output, CNT_W: saturating count of mismatches seen in LOCKED.
- bit_count, output, CNT_W: saturating count of bits checked in LOCKED.

## Operation
- Internal state:
  - shadow register S[WIDTH-1:0]
  - fill counter
  - match counter
  - consecutive-error counter
  - FSM with states SEED, QUAL, LOCKED
- Expected bit: exp = ^(S & TAPS), computed from S before the update.
- Only cycles with in_valid=1 advance the FSM, S, or the counters. With in_valid=0, all state holds and err_pulse=0.
- SEED:
  - Each valid bit: S <= {S[WIDTH-2:0], in_bit}; fill counter +1.
  - When the WIDTH-th bit is shifted in, the next state depends on the value S will hold after that shift:
    - If that value is nonzero: go to QUAL with match counter = 0.
    - If that value is all-zero (an illegal LFSR state): stay in SEED and set the fill counter to 0.
- QUAL:
  - Each valid bit: S <= {S[WIDTH-2:0], in_bit}.
  - If in_bit == exp: match counter +1. Reaching LOCK_CNT moves the FSM to LOCKED.
  - If in_bit != exp: go to SEED with the fill counter set to 1. This bit has already been shifted into S, so it counts as the first seed bit.
- LOCKED:
  - Each valid bit: S <= {S[WIDTH-2:0], exp}. The shadow free-runs and is not corrupted by received errors.
  - bit_count +1 (saturating).
  - On a mismatch:
    - err_pulse=1 next cycle
    - err_count +1 (saturating)
    - consecutive-error counter +1
  - On a match: consecutive-error counter clears.
  - When the consecutive-error counter reaches LOSS_THRESH: go to SEED with the fill counter at 0 and locked falling on the same edge. err_count and bit_count are retained.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear: err_count and bit_count go to 0 on the edge.
  - If clear coincides with an increment, clear wins and the result is 0.
  - clear does not affect the FSM or S.
- Reset may be asserted mid-operation at any point. All state returns immediately to reset values; no partial lock is retained.

## Timing
- Reset values:
  - FSM = SEED
  - S = 0
  - all internal counters = 0
  - locked = 0
  - err_pulse = 0
  - err_count = 0
  - bit_count = 0
- All outputs are registered; no combinational input-to-output path.
- Lock latency from reset, with an error-free stream: locked rises on the edge that samples the (WIDTH+LOCK_CNT)-th valid bit. With the defaults this is the 7th valid bit.
- err_pulse is high for exactly the cycle after the edge that samples a mismatching bit in LOCKED. err_count reflects that mismatch in the same cycle.
- Loss: locked falls on the edge that samples the LOSS_THRESH-th consecutive mismatch. That bit also raises err_pulse and increments err_count.
- Throughput: one bit per clock, with no dead cycles on state transitions.

## Test plan
All scenarios use the default parameters. The reference stream is the generator output from seed 001: bits 1,1,0,1,0,0,1, repeating with period 7.

- Continuous error-free stream → locked=1 after the 7th valid bit; after 100 further bits, bit_count=100, err_count=0, err_pulse never asserted.
- Locked stream with 4th-from-lock bit inverted once → err_pulse high one cycle; err_count=1; locked stays 1; subsequent bits match (shadow not corrupted).
- Locked, then 3 consecutive inverted bits → err_count=3; locked falls on the 3rd mismatch; re-lock occurs 7 valid bits after clean data resumes, provided the first 3 seed bits form a nonzero state.
- Stream of all zeros from reset → stays in SEED forever; locked=0; counters 0.
- in_valid toggled 1,0,1,0 over a clean stream → lock takes 7 valid bits (13 clocks); idle cycles change nothing.
- Saturation/clear/reset:
  - With CNT_W=2 and 5 isolated errors while locked → err_count=3.
  - clear coincident with an error → err_count=0.
  - Reset asserted while locked → all outputs 0 immediately, without waiting for a clock edge.
